ddr3_axi_traffic_gen: RTL and testbench

AXI4 master built-in self-test that drives the AXI slave port of the DDR3 AXI top-level. On a start pulse it writes a deterministic pattern across a contiguous region using INCR bursts, reads the region back, and compares every beat. It then reports pass/fail, an error count and the first failing address. It sits directly upstream of the DDR3 AXI controller on the controller clock, and is used for board bring-up and regression.

---
 rtl/ddr3_axi_traffic_gen.sv | 191 +++++++++++++++++++
 tb/tb_ddr3_axi_traffic_gen.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_axi_traffic_gen.sv
// AXI4 write/read-back self-test master for the DDR3 AXI slave port.
// Writes a seeded per-beat pattern in INCR bursts, reads it back, counts mismatches.
//
// state   | meaning
// S_IDLE  | waiting for i_start after reset
// S_W_ADDR| presenting write burst address
// S_W_DATA| streaming write beats of the current burst
// S_W_RESP| waiting for the write response
// S_R_ADDR| presenting read burst address
// S_R_DATA| receiving and comparing read beats
// S_DONE  | results valid, waiting for a new i_start
module ddr3_axi_traffic_gen #(
  parameter int                        AXI_ID_WIDTH   = 4,
  parameter int                        AXI_ADDR_WIDTH = 28,
  parameter int                        AXI_DATA_WIDTH = 128,
  parameter int                        BURST_LEN      = 16,
  parameter int                        NUM_BURSTS     = 64,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter logic [31:0]               SEED           = 32'hA5A5_0000
) (
  input  logic                        i_controller_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_pass,
  output logic [15:0]                 o_err_count,
  output logic [AXI_ADDR_WIDTH-1:0]   o_first_err_addr,
  output logic                        m_axi_awvalid,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic                        m_axi_awlock,
  output logic [3:0]                  m_axi_awcache,
  output logic [2:0]                  m_axi_awprot,
  output logic [3:0]                  m_axi_awqos,
  input  logic                        m_axi_awready,
  output logic                        m_axi_wvalid,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  input  logic                        m_axi_wready,
  input  logic                        m_axi_bvalid,
  input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]                  m_axi_bresp,
  output logic                        m_axi_bready,
  output logic                        m_axi_arvalid,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]                  m_axi_arlen,
  output logic [2:0]                  m_axi_arsize,
  output logic [1:0]                  m_axi_arburst,
  output logic                        m_axi_arlock,
  output logic [3:0]                  m_axi_arcache,
  output logic [2:0]                  m_axi_arprot,
  output logic [3:0]                  m_axi_arqos,
  input  logic                        m_axi_arready,
  input  logic                        m_axi_rvalid,
  input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic                        m_axi_rlast,
  input  logic [1:0]                  m_axi_rresp,
  output logic                        m_axi_rready
);

  localparam int         BYTES       = AXI_DATA_WIDTH / 8;
  localparam int         BURST_BYTES = BURST_LEN * BYTES;
  localparam int         WORDS       = AXI_DATA_WIDTH / 32;
  localparam logic [7:0]  LAST_BEAT  = 8'(BURST_LEN - 1);
  localparam logic [15:0] LAST_BURST = 16'(NUM_BURSTS - 1);
  localparam logic [2:0]  SIZE       = 3'($clog2(BYTES));

  typedef enum logic [2:0] {
    S_IDLE, S_W_ADDR, S_W_DATA, S_W_RESP, S_R_ADDR, S_R_DATA, S_DONE
  } state_t;

  state_t                    state, state_next;
  logic [15:0]               burst_cnt;
  logic [7:0]                beat_cnt;
  logic [15:0]               err_count;
  logic [AXI_ADDR_WIDTH-1:0] first_err_addr;
  logic [31:0]               beat_idx;
  logic [AXI_DATA_WIDTH-1:0] exp_data;
  logic [AXI_ADDR_WIDTH-1:0] burst_addr, beat_addr, err_addr;
  logic                      last_beat, last_burst, start_ok;
  logic                      aw_hs, w_hs, b_hs, ar_hs, r_hs, r_err, err_event;
  logic                      unused_ids;

  assign unused_ids = ^{m_axi_bid, m_axi_rid};

  // Global beat index drives both the write pattern and the read-back compare.
  assign beat_idx   = 32'(burst_cnt) * 32'(BURST_LEN) + 32'(beat_cnt);
  assign exp_data   = {WORDS{beat_idx ^ SEED}};
  assign burst_addr = BASE_ADDR + AXI_ADDR_WIDTH'(burst_cnt) * AXI_ADDR_WIDTH'(BURST_BYTES);
  assign beat_addr  = burst_addr + AXI_ADDR_WIDTH'(beat_cnt) * AXI_ADDR_WIDTH'(BYTES);
  assign last_beat  = (beat_cnt == LAST_BEAT);
  assign last_burst = (burst_cnt == LAST_BURST);
  assign start_ok   = ((state == S_IDLE) || (state == S_DONE)) && i_start;

  assign m_axi_awvalid = (state == S_W_ADDR);
  assign m_axi_wvalid  = (state == S_W_DATA);
  assign m_axi_bready  = (state == S_W_RESP);
  assign m_axi_arvalid = (state == S_R_ADDR);
  assign m_axi_rready  = (state == S_R_DATA);

  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid & m_axi_wready;
  assign b_hs  = m_axi_bvalid & m_axi_bready;
  assign ar_hs = m_axi_arvalid & m_axi_arready;
  assign r_hs  = m_axi_rvalid & m_axi_rready;

  assign r_err     = (m_axi_rdata != exp_data) | (m_axi_rresp != 2'b00) | (m_axi_rlast != last_beat);
  assign err_event = (r_hs & r_err) | (b_hs & (m_axi_bresp != 2'b00));
  assign err_addr  = (state == S_W_RESP) ? burst_addr : beat_addr;

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = burst_addr;
  assign m_axi_awlen   = LAST_BEAT;
  assign m_axi_awsize  = SIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_arid    = '0;
  assign m_axi_araddr  = burst_addr;
  assign m_axi_arlen   = LAST_BEAT;
  assign m_axi_arsize  = SIZE;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;
  assign m_axi_wdata   = exp_data;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = m_axi_wvalid & last_beat;

  assign o_busy           = (state != S_IDLE) && (state != S_DONE);
  assign o_done           = (state == S_DONE);
  assign o_pass           = o_done && (err_count == 16'd0);
  assign o_err_count      = err_count;
  assign o_first_err_addr = first_err_addr;

  always_ff @(posedge i_controller_clk) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (i_start) state_next = S_W_ADDR;
      S_W_ADDR:       if (aw_hs) state_next = S_W_DATA;
      S_W_DATA:       if (w_hs && last_beat) state_next = S_W_RESP;
      S_W_RESP:       if (b_hs) state_next = last_burst ? S_R_ADDR : S_W_ADDR;
      S_R_ADDR:       if (ar_hs) state_next = S_R_DATA;
      S_R_DATA:       if (r_hs && m_axi_rlast) state_next = last_burst ? S_DONE : S_R_ADDR;
      default:        state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_controller_clk) begin
    if (!i_rst_n) begin
      burst_cnt      <= '0;
      beat_cnt       <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      if (start_ok) begin
        burst_cnt      <= '0;
        beat_cnt       <= '0;
        err_count      <= '0;
        first_err_addr <= '0;
      end
      if (w_hs) beat_cnt <= last_beat ? 8'd0 : beat_cnt + 8'd1;
      if (b_hs) burst_cnt <= last_burst ? 16'd0 : burst_cnt + 16'd1;
      // The slave's rlast, not the local count, closes a read burst.
      if (r_hs) begin
        beat_cnt <= m_axi_rlast ? 8'd0 : beat_cnt + 8'd1;
        if (m_axi_rlast) burst_cnt <= last_burst ? 16'd0 : burst_cnt + 16'd1;
      end
      if (err_event) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == 16'd0) first_err_addr <= err_addr;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_axi_traffic_gen.sv
// Scoreboard bench for ddr3_axi_traffic_gen: 2 bursts of 4 x 128-bit beats against a
// behavioural AXI memory slave with optional backpressure and fault injection.
module tb_ddr3_axi_traffic_gen;

  localparam logic [31:0] SEED = 32'hA5A5_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic         busy, done, pass;
  logic [15:0]  err_count;
  logic [27:0]  first_err_addr;
  logic         awvalid, awready, awlock, wvalid, wready, wlast;
  logic [3:0]   awid, awcache, awqos, arid, arcache, arqos, bid, rid;
  logic [27:0]  awaddr, araddr;
  logic [7:0]   awlen, arlen;
  logic [2:0]   awsize, awprot, arsize, arprot;
  logic [1:0]   awburst, arburst, bresp, rresp;
  logic [127:0] wdata, rdata;
  logic [15:0]  wstrb;
  logic         bvalid, bready, arvalid, arready, arlock, rvalid, rlast, rready;

  always #5 clk = ~clk;

  ddr3_axi_traffic_gen #(
    .AXI_ID_WIDTH(4), .AXI_ADDR_WIDTH(28), .AXI_DATA_WIDTH(128),
    .BURST_LEN(4), .NUM_BURSTS(2), .BASE_ADDR(28'h0), .SEED(SEED)
  ) dut (
    .i_controller_clk(clk), .i_rst_n(rst_n), .i_start(i_start),
    .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_err_count(err_count), .o_first_err_addr(first_err_addr),
    .m_axi_awvalid(awvalid), .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
    .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awlock(awlock),
    .m_axi_awcache(awcache), .m_axi_awprot(awprot), .m_axi_awqos(awqos),
    .m_axi_awready(awready),
    .m_axi_wvalid(wvalid), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wready(wready),
    .m_axi_bvalid(bvalid), .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bready(bready),
    .m_axi_arvalid(arvalid), .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arlock(arlock),
    .m_axi_arcache(arcache), .m_axi_arprot(arprot), .m_axi_arqos(arqos),
    .m_axi_arready(arready),
    .m_axi_rvalid(rvalid), .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rlast(rlast),
    .m_axi_rresp(rresp), .m_axi_rready(rready)
  );

  typedef struct packed { logic [127:0] data; logic last; } wbeat_t;
  typedef struct packed { logic [15:0] err; logic [27:0] addr; logic pass; } status_t;

  logic [27:0] exp_aw[$];
  logic [27:0] exp_ar[$];
  wbeat_t      exp_w[$];
  status_t     exp_st[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  function automatic logic [127:0] rep(input logic [31:0] v);
    return {4{v}};
  endfunction

  // ---------------- slave model ----------------
  logic [127:0] mem [0:7];
  logic bp = 1'b0, fault_rflip = 1'b0, fault_bresp = 1'b0;
  int w_idx, r_idx, r_beat, b_burst;
  logic b_pend, r_act;
  int n_aw, n_w, n_b, n_ar, n_r;

  task automatic slave_idle();
    awready = 0; wready = 0; arready = 0;
    bvalid = 0; bid = '0; bresp = '0;
    rvalid = 0; rid = '0; rdata = '0; rlast = 0; rresp = '0;
    b_pend = 0; r_act = 0; w_idx = 0; r_idx = 0; r_beat = 0; b_burst = 0;
  endtask

  initial begin
    slave_idle();
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        slave_idle();
      end else begin
        awready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        wready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        arready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        bvalid  = b_pend;
        bresp   = (b_pend && fault_bresp && b_burst == 1) ? 2'b10 : 2'b00;
        rvalid  = r_act;
        rdata   = (r_act && r_idx < 8) ? mem[r_idx] : '0;
        if (r_act && fault_rflip && r_idx == 3) rdata[0] = ~rdata[0];
        rlast   = r_act && (r_beat == 3);
        rresp   = 2'b00;
        #1;
        if (bvalid && bready) begin b_pend = 0; n_b++; end
        if (awvalid && awready) begin w_idx = int'(awaddr) / 16; n_aw++; end
        if (wvalid && wready) begin
          if (w_idx < 8) mem[w_idx] = wdata;
          if (wlast) begin b_pend = 1; b_burst = w_idx / 4; end
          w_idx++; n_w++;
        end
        if (rvalid && rready) begin
          n_r++; r_idx++; r_beat++;
          if (r_beat == 4) r_act = 0;
        end
        if (arvalid && arready) begin
          r_idx = int'(araddr) / 16; r_beat = 0; r_act = 1; n_ar++;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int           w_seen;
  logic         done_q, aw_stall, w_stall;
  logic [27:0]  aw_hold;
  logic [128:0] w_hold;

  initial begin
    done_q = 0; aw_stall = 0; w_stall = 0; aw_hold = '0; w_hold = '0;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        done_q = 0; aw_stall = 0; w_stall = 0;
      end else begin
        if (aw_stall) check("aw_stable", {awvalid, awaddr}, {1'b1, aw_hold});
        if (w_stall)  check("w_stable", {wvalid, wdata, wlast}, {1'b1, w_hold});
        aw_stall = awvalid && !awready; aw_hold = awaddr;
        w_stall  = wvalid && !wready;   w_hold  = {wdata, wlast};
        if (awvalid && awready) begin
          if (exp_aw.size() == 0) fail_now("aw_unexpected");
          else begin
            check("awaddr", awaddr, exp_aw.pop_front());
            check("aw_fields", {awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos},
                  {4'd0, 8'd3, 3'd4, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});
          end
        end
        if (wvalid && wready) begin
          if (exp_w.size() == 0) fail_now("w_unexpected");
          else begin
            wbeat_t e;
            e = exp_w.pop_front();
            check("wdata", wdata, e.data);
            check("wlast", wlast, e.last);
            check("wstrb", wstrb, 16'hFFFF);
            if (w_seen == 0) check("w_beat0_seed", wdata, 128'hA5A50000_A5A50000_A5A50000_A5A50000);
            if (w_seen == 5) check("w_beat5", wdata, 128'hA5A50005_A5A50005_A5A50005_A5A50005);
          end
          w_seen++;
        end
        if (arvalid && arready) begin
          if (exp_ar.size() == 0) fail_now("ar_unexpected");
          else check("araddr", {araddr, arlen, arsize, arburst}, {exp_ar.pop_front(), 8'd3, 3'd4, 2'b01});
        end
        if (done && !done_q) begin
          if (exp_st.size() == 0) fail_now("done_unexpected");
          else begin
            status_t s;
            s = exp_st.pop_front();
            check("err_count", err_count, s.err);
            check("first_err_addr", first_err_addr, s.addr);
            check("pass", {pass, busy}, {s.pass, 1'b0});
          end
        end
        done_q = done;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic expect_run(input logic [15:0] e_err, input logic [27:0] e_addr, input logic e_pass);
    status_t s;
    exp_aw.push_back(28'h00); exp_aw.push_back(28'h40);
    exp_ar.push_back(28'h00); exp_ar.push_back(28'h40);
    for (int b = 0; b < 8; b++) begin
      wbeat_t e;
      e.data = rep(32'(b) ^ SEED);
      e.last = (b % 4 == 3);
      exp_w.push_back(e);
    end
    s.err = e_err; s.addr = e_addr; s.pass = e_pass;
    exp_st.push_back(s);
    w_seen = 0; n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 3000) begin @(negedge clk); n++; end
    if (!done) fail_now("done_timeout");
  endtask

  task automatic post_checks(input string name);
    repeat (2) @(negedge clk);
    check({name, "_drained"}, 128'(exp_aw.size() + exp_w.size() + exp_ar.size() + exp_st.size()), 128'd0);
    check({name, "_hs_counts"}, {8'(n_aw), 8'(n_w), 8'(n_b), 8'(n_ar), 8'(n_r)},
          {8'd2, 8'd8, 8'd2, 8'd2, 8'd8});
  endtask

  task automatic run_pass(input string name, input logic [15:0] e_err,
                          input logic [27:0] e_addr, input logic e_pass, input logic from_done);
    expect_run(e_err, e_addr, e_pass);
    @(negedge clk); i_start = 1;
    @(negedge clk); i_start = 0;
    if (from_done)
      check("restart_clear", {done, busy, err_count, first_err_addr}, {1'b0, 1'b1, 16'd0, 28'd0});
    wait_done();
    post_checks(name);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", {awvalid, wvalid, bready, arvalid, rready, busy, done, pass},
          8'b0000_0000);
    check("reset_status", {err_count, first_err_addr}, 44'd0);
    rst_n = 1;

    run_pass("basic", 16'd0, 28'd0, 1'b1, 1'b0);

    bp = 1;
    run_pass("backpressure", 16'd0, 28'd0, 1'b1, 1'b0);
    bp = 0;

    fault_rflip = 1;
    run_pass("rdata_flip", 16'd1, 28'd48, 1'b0, 1'b0);
    fault_rflip = 0;

    fault_bresp = 1;
    run_pass("bresp_err", 16'd1, 28'd64, 1'b0, 1'b0);
    fault_bresp = 0;

    run_pass("start_in_done", 16'd0, 28'd0, 1'b1, 1'b1);

    // Abort in the middle of the write data phase.
    begin
      int n;
      expect_run(16'd0, 28'd0, 1'b1);
      @(negedge clk); i_start = 1;
      @(negedge clk); i_start = 0;
      n = 0;
      while (!wvalid && n < 100) begin @(negedge clk); n++; end
      if (!wvalid) fail_now("wdata_phase_timeout");
      @(negedge clk);
      rst_n = 0;
      @(negedge clk);
      check("mid_reset", {awvalid, wvalid, bready, arvalid, rready, busy, done}, 7'b0);
      rst_n = 1;
      exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_st.delete();
    end
    run_pass("after_reset", 16'd0, 28'd0, 1'b1, 1'b0);

    // i_start held through a run must not cause a second pass.
    expect_run(16'd0, 28'd0, 1'b1);
    @(negedge clk); i_start = 1;
    repeat (12) @(negedge clk);
    check("held_start_busy", busy, 1'b1);
    i_start = 0;
    wait_done();
    repeat (4) @(negedge clk);
    check("held_start_idle", {done, busy}, 2'b10);
    post_checks("held_start");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
